// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive paths: parity encodings,
// transmitter state encoding and baud-rate helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Integer division rounded to nearest, so 50 MHz / 115200 gives 434.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head entry is presented
// combinationally so the consumer can pop and use the data in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_acc;
    logic             pop_acc;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign rdata    = mem[rd_ptr_reg];
    // A push is judged on full alone, so a pop on the same edge never frees room early.
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// RS-232 transmitter: bytes queue in a small FIFO and are framed LSB-first
// with start, optional parity and stop bits at a fixed baud rate.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLK_HZ       = 50000000,
    parameter  int BAUD         = 115200,
    parameter  int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
    parameter  int PARITY       = PAR_NONE,
    parameter  int STOP_BITS    = 1,
    parameter  int FIFO_DEPTH   = 4,
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);

    tx_state_t         state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              parity_reg;
    logic              tx_reg;

    logic [7:0]        head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              bit_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign tx       = tx_reg;
    assign busy     = (state_reg != S_IDLE) || !fifo_empty;
    assign bit_done = (baud_cnt_reg == '0);

    // Popping on the last stop cycle chains frames with no idle gap.
    always_comb begin
        fifo_pop = 1'b0;
        case (state_reg)
            S_IDLE:  fifo_pop = !fifo_empty;
            S_STOP:  fifo_pop = bit_done && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                end
                S_START: begin
                    if (bit_done) begin
                        tx_reg       <= shift_reg[0];
                        baud_cnt_reg <= BIT_LAST;
                        state_reg    <= S_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (!bit_done) begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end else if (bit_idx_reg != 3'd7) begin
                        bit_idx_reg  <= bit_idx_reg + 3'd1;
                        shift_reg    <= shift_reg >> 1;
                        tx_reg       <= shift_reg[1];
                        baud_cnt_reg <= BIT_LAST;
                    end else if (PARITY != PAR_NONE) begin
                        bit_idx_reg  <= '0;
                        tx_reg       <= parity_reg;
                        baud_cnt_reg <= BIT_LAST;
                        state_reg    <= S_PARITY;
                    end else begin
                        bit_idx_reg  <= '0;
                        tx_reg       <= 1'b1;
                        baud_cnt_reg <= STOP_LAST;
                        state_reg    <= S_STOP;
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        tx_reg       <= 1'b1;
                        baud_cnt_reg <= STOP_LAST;
                        state_reg    <= S_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        state_reg <= S_IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - BAUD_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase

            // Loading a new frame overrides whatever the state above decided.
            if (fifo_pop) begin
                shift_reg    <= head_data;
                parity_reg   <= parity_bit(head_data, PARITY);
                tx_reg       <= 1'b0;
                baud_cnt_reg <= BIT_LAST;
                bit_idx_reg  <= '0;
                state_reg    <= S_START;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8O1, 8E1, 8N2) at 10 clocks/bit;
// a line monitor decodes frames and checks them against a queue of expected bytes.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB = 10;

    typedef struct {
        logic [7:0] data;
        int         par;
        int         stops;
        bit         gap0;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0][7:0] din;
    logic [3:0]      vld;
    logic [3:0]      rdy;
    logic [3:0]      txl;
    logic [3:0]      bsy;
    logic [3:0][2:0] cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic mon_en = 1'b0;
    int   mon_sel = 0;
    bit   mon_busy = 1'b0;
    logic mon_tx;
    logic [2:0] maxcnt;

    always #5 clk = ~clk;
    assign mon_tx = txl[mon_sel];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            uart_tx_fifo #(
                .CLK_HZ     (1000000),
                .BAUD       (100000),
                .PARITY     (gi == 1 ? PAR_ODD : (gi == 2 ? PAR_EVEN : PAR_NONE)),
                .STOP_BITS  (gi == 3 ? 2 : 1),
                .FIFO_DEPTH (4)
            ) u_dut (
                .clk        (clk),
                .reset      (reset),
                .tx_data    (din[gi]),
                .tx_valid   (vld[gi]),
                .tx_ready   (rdy[gi]),
                .tx         (txl[gi]),
                .busy       (bsy[gi]),
                .fifo_count (cnt[gi])
            );
        end
    endgenerate

    always @(negedge clk) begin
        if (reset) maxcnt <= '0;
        else if (cnt[0] > maxcnt) maxcnt <= cnt[0];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Scoreboard monitor: every start bit pops one expectation and the whole
    // frame is compared sample-by-sample, including the idle gap before it.
    initial begin : monitor
        int         gap;
        int         nb;
        int         errs;
        exp_t       e;
        logic [11:0] bits;
        gap = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || mon_tx !== 1'b0) begin
                gap++;
            end else begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame: unexpected start bit on dut%0d, required no frame", mon_sel);
                    e.data = 8'h00; e.par = PAR_NONE; e.stops = 1; e.gap0 = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                end
                bits = '0;
                for (int k = 0; k < 8; k++) bits[k+1] = e.data[k];
                nb = 9;
                if (e.par != PAR_NONE) begin
                    bits[9] = (e.par == PAR_ODD) ? ~^e.data : ^e.data;
                    nb = 10;
                end
                for (int k = 0; k < e.stops; k++) begin
                    bits[nb] = 1'b1;
                    nb++;
                end
                errs = 0;
                for (int s = 0; s < nb * CPB; s++) begin
                    if (s > 0) @(negedge clk);
                    if (mon_tx !== bits[s / CPB]) errs++;
                end
                checks++;
                if (errs != 0 || (e.gap0 && gap != 0)) begin
                    errors++;
                    $display("FAIL frame dut%0d data=%02h: %0d bad samples, gap %0d; required 0 bad samples%s",
                             mon_sel, e.data, errs, gap, e.gap0 ? ", gap 0" : "");
                end else begin
                    $display("ok   frame dut%0d data=%02h len=%0d gap=%0d", mon_sel, e.data, nb * CPB, gap);
                end
                gap = 0;
                mon_busy = 1'b0;
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input int i, input logic [7:0] d, input int par, input int stops,
                        input bit gap0, output int waited);
        exp_t e;
        din[i] = d;
        vld[i] = 1'b1;
        waited = 0;
        while (!rdy[i] && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 1000) check("push ready timeout", waited, 0);
        @(posedge clk); #1;
        if (mon_en) begin
            e.data = d; e.par = par; e.stops = stops; e.gap0 = gap0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int i);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy || bsy[i]) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain completes in budget", int'(t < 5000), 1);
    endtask

    task automatic run_one(input int i, input logic [7:0] d, input int par, input int stops, input int len);
        int w;
        int n;
        mon_sel = i;
        push(i, d, par, stops, 1'b0, w);
        vld[i] = 1'b0;
        check("fifo_count after push", int'(cnt[i]), 1);
        check("busy after push", int'(bsy[i]), 1);
        check("tx still idle at E+1", int'(txl[i]), 1);
        @(posedge clk); #1;
        check("tx start bit from E+2", int'(txl[i]), 0);
        n = 1;
        while (bsy[i] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("cycles from push to busy fall", n, len + 1);
        wait_done(i);
    endtask

    initial begin : stimulus
        int w;
        int lows;
        din = '0;
        vld = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset tx", int'(txl[i]), 1);
            check("reset busy", int'(bsy[i]), 0);
            check("reset tx_ready", int'(rdy[i]), 1);
            check("reset fifo_count", int'(cnt[i]), 0);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_one(0, 8'h55, PAR_NONE, 1, 100);
        run_one(1, 8'h03, PAR_ODD,  1, 110);
        run_one(2, 8'h03, PAR_EVEN, 1, 110);
        run_one(3, 8'hFF, PAR_NONE, 2, 110);

        // Back-to-back stream with tx_valid held high through a full FIFO.
        mon_sel = 0;
        push(0, 8'h01, PAR_NONE, 1, 1'b0, w);
        for (int b = 2; b <= 5; b++) push(0, 8'(b), PAR_NONE, 1, 1'b1, w);
        check("fifo_count when full", int'(cnt[0]), 4);
        check("tx_ready low when full", int'(rdy[0]), 0);
        din[0] = 8'h06;
        w = 0;
        while (!rdy[0] && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        check("waited for room (cycles>0)", int'(w > 0 && w < 1000), 1);
        check("push blocked on pop edge, count 4->3", int'(cnt[0]), 3);
        @(posedge clk); #1;
        check("byte 6 accepted next edge", int'(cnt[0]), 4);
        exp_q.push_back('{8'h06, PAR_NONE, 1, 1'b1});
        vld[0] = 1'b0;
        wait_done(0);
        check("max fifo_count", int'(maxcnt), 4);

        // Reset during data bit 3 with two bytes still queued.
        mon_en = 1'b0;
        push(0, 8'hA5, PAR_NONE, 1, 1'b0, w);
        push(0, 8'h3C, PAR_NONE, 1, 1'b0, w);
        push(0, 8'h0F, PAR_NONE, 1, 1'b0, w);
        vld[0] = 1'b0;
        repeat (43) begin
            @(posedge clk); #1;
        end
        check("queued bytes before reset", int'(cnt[0]), 2);
        check("tx is data bit 3 of A5", int'(txl[0]), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("tx high after mid-frame reset", int'(txl[0]), 1);
        check("fifo_count cleared by reset", int'(cnt[0]), 0);
        check("busy cleared by reset", int'(bsy[0]), 0);
        check("tx_ready after reset", int'(rdy[0]), 1);
        lows = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (txl[0] !== 1'b1) lows++;
        end
        check("no frame after reset (low cycles)", lows, 0);
        check("expected queue drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
